axi_frame_read_ctrl: RTL and testbench

Sequences AXI4 read bursts that fetch a rectangular frame (line_count lines of line_beats words, line pitch stride bytes) from the image RAM. It forwards the returned beats as an AXI-Stream with start-of-frame and end-of-line markers. It sits between the top-level start/config logic and the AXI read channel of the frame memory, and feeds the rectify datapath's stream input.

---
 rtl/axi_frame_read_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_axi_frame_read_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_frame_read_ctrl.sv
// Frame fetch sequencer: walks a rectangular frame with AXI4 INCR read bursts
// (one outstanding, never crossing 4 KB) and forwards beats as an AXI-Stream.
module axi_frame_read_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int ID_WIDTH   = 8,
   parameter int MAX_BURST  = 16
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [15:0]           line_beats,
   input  logic [15:0]           line_count,
   input  logic [ADDR_WIDTH-1:0] stride,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [ID_WIDTH-1:0]   m_axi_arid,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic                  m_axi_arlock,
   output logic [3:0]            m_axi_arcache,
   output logic [2:0]            m_axi_arprot,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [ID_WIDTH-1:0]   m_axi_rid,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int SIZE  = $clog2(BYTES);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;
   localparam logic [1:0] S_FIN  = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [15:0]           beats_cfg_q, beats_cfg_d;
   logic [15:0]           lines_cfg_q, lines_cfg_d;
   logic [ADDR_WIDTH-1:0] stride_q, stride_d;
   logic [15:0]           line_q, line_d;
   logic [ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [15:0]           beats_left_q, beats_left_d;
   logic [8:0]            burst_cnt_q, burst_cnt_d;
   logic [7:0]            arlen_q, arlen_d;
   logic                  first_q, first_d;
   logic                  err_q, err_d;

   logic                  beat_hs;
   logic                  burst_last;
   logic [8:0]            burst_len;
   logic [ADDR_WIDTH-1:0] burst_bytes;
   logic [ADDR_WIDTH-1:0] next_line_addr;

   // Beats allowed from address a: capped by what remains in the line, by
   // MAX_BURST, and by the distance to the next 4 KB page.
   function automatic logic [8:0] calc_len(input logic [ADDR_WIDTH-1:0] a,
                                           input logic [15:0] left);
      logic [31:0] a32;
      logic [12:0] to_page;
      logic [16:0] len;
      a32     = 32'(a);
      to_page = (13'd4096 - {1'b0, a32[11:0]}) >> SIZE;
      len     = {1'b0, left};
      if (len > 17'(MAX_BURST)) len = 17'(MAX_BURST);
      if (len > {4'd0, to_page}) len = {4'd0, to_page};
      return len[8:0];
   endfunction

   assign beat_hs        = (state_q == S_DATA) && m_axi_rvalid && m_axis_tready;
   assign burst_last     = (burst_cnt_q == 9'd1);
   assign burst_len      = {1'b0, arlen_q} + 9'd1;
   assign burst_bytes    = ADDR_WIDTH'(burst_len) << SIZE;
   assign next_line_addr = line_addr_q + stride_q;

   always_comb begin
      // NOTE: every next-state variable takes its held value first, so no path leaves it unassigned and no latch is inferred.
      state_d      = state_q;
      beats_cfg_d  = beats_cfg_q;
      lines_cfg_d  = lines_cfg_q;
      stride_d     = stride_q;
      line_d       = line_q;
      line_addr_d  = line_addr_q;
      addr_d       = addr_q;
      beats_left_d = beats_left_q;
      burst_cnt_d  = burst_cnt_q;
      first_d      = first_q;
      err_d        = err_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               beats_cfg_d = line_beats;
               lines_cfg_d = line_count;
               stride_d    = stride;
               err_d       = 1'b0;
               if (line_beats == 16'd0 || line_count == 16'd0) begin
                  state_d = S_FIN;
               end else begin
                  line_d       = 16'd0;
                  line_addr_d  = base_addr;
                  addr_d       = base_addr;
                  beats_left_d = line_beats;
                  first_d      = 1'b1;
                  state_d      = S_ADDR;
               end
            end
         end
         S_ADDR: begin
            if (m_axi_arready) begin
               beats_left_d = beats_left_q - {7'd0, burst_len};
               burst_cnt_d  = burst_len;
               state_d      = S_DATA;
            end
         end
         S_DATA: begin
            if (beat_hs) begin
               burst_cnt_d = burst_cnt_q - 9'd1;
               first_d     = 1'b0;
               // Protocol anomalies are flagged but the beat is still delivered.
               if ((m_axi_rlast != burst_last) || (m_axi_rresp != 2'b00) ||
                   (m_axi_rid != '0))
                  err_d = 1'b1;
               if (burst_last) begin
                  if (beats_left_q != 16'd0) begin
                     addr_d  = addr_q + burst_bytes;
                     state_d = S_ADDR;
                  end else if (({1'b0, line_q} + 17'd1) < {1'b0, lines_cfg_q}) begin
                     line_d       = line_q + 16'd1;
                     line_addr_d  = next_line_addr;
                     addr_d       = next_line_addr;
                     beats_left_d = beats_cfg_q;
                     state_d      = S_ADDR;
                  end else begin
                     state_d = S_FIN;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // arlen is fixed on entry to ADDR so it stays stable across arready stalls.
   always_comb begin
      arlen_d = arlen_q;
      if (state_d == S_ADDR && state_q != S_ADDR)
         arlen_d = 8'(calc_len(addr_d, beats_left_d) - 9'd1);
   end

   // NOTE: sequential state uses non-blocking assignments only; the async reset covers every flop because none of them is a memory array.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= S_IDLE;
         beats_cfg_q  <= '0;
         lines_cfg_q  <= '0;
         stride_q     <= '0;
         line_q       <= '0;
         line_addr_q  <= '0;
         addr_q       <= '0;
         beats_left_q <= '0;
         burst_cnt_q  <= '0;
         arlen_q      <= '0;
         first_q      <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         beats_cfg_q  <= beats_cfg_d;
         lines_cfg_q  <= lines_cfg_d;
         stride_q     <= stride_d;
         line_q       <= line_d;
         line_addr_q  <= line_addr_d;
         addr_q       <= addr_d;
         beats_left_q <= beats_left_d;
         burst_cnt_q  <= burst_cnt_d;
         arlen_q      <= arlen_d;
         first_q      <= first_d;
         err_q        <= err_d;
      end
   end

   assign m_axi_arid    = '0;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arlen   = arlen_q;
   assign m_axi_arsize  = 3'(SIZE);
   assign m_axi_arburst = 2'b01;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = 4'b0011;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arvalid = (state_q == S_ADDR);

   assign m_axi_rready  = (state_q == S_DATA) && m_axis_tready;
   assign m_axis_tvalid = (state_q == S_DATA) && m_axi_rvalid;
   assign m_axis_tdata  = m_axi_rdata;
   assign m_axis_tlast  = (state_q == S_DATA) && burst_last && (beats_left_q == 16'd0);
   assign m_axis_tuser  = (state_q == S_DATA) && first_q;

   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_FIN);
   assign err  = err_q;

endmodule

// File: tb/tb_axi_frame_read_ctrl.sv
// Scoreboard bench for axi_frame_read_ctrl: an AXI read slave serves a synthetic
// memory while expected ARs and stream beats are queued from a frame model.
module tb_axi_frame_read_ctrl;

   localparam int DW = 32;
   localparam int AW = 16;
   localparam int IW = 8;
   localparam int MB = 16;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [15:0]   line_beats = '0;
   logic [15:0]   line_count = '0;
   logic [AW-1:0] stride = '0;
   logic          busy, done, err;
   logic [IW-1:0] arid;
   logic [AW-1:0] araddr;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;
   logic          arlock;
   logic [3:0]    arcache;
   logic [2:0]    arprot;
   logic          arvalid;
   logic          arready = 1'b0;
   logic [IW-1:0] rid = '0;
   logic [DW-1:0] rdata = '0;
   logic [1:0]    rresp = '0;
   logic          rlast = 1'b0;
   logic          rvalid = 1'b0;
   logic          rready;
   logic [DW-1:0] tdata;
   logic          tvalid;
   logic          tready = 1'b1;
   logic          tlast, tuser;

   axi_frame_read_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MAX_BURST(MB)) dut (
      .aclk(aclk), .aresetn(aresetn), .start(start), .base_addr(base_addr),
      .line_beats(line_beats), .line_count(line_count), .stride(stride),
      .busy(busy), .done(done), .err(err),
      .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
      .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
      .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
      .m_axi_rvalid(rvalid), .m_axi_rready(rready),
      .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
      .m_axis_tlast(tlast), .m_axis_tuser(tuser)
   );

   always #5 aclk = ~aclk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  len;
   } ar_t;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic        user;
   } beat_t;

   ar_t   exp_ar[$];
   beat_t exp_beat[$];

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      return {~a, a} ^ 32'h5A5A_1234;
   endfunction

   // Monitor/slave shared state
   int          cyc = 0;
   int          start_cyc = -10;
   int          last_beat_cyc = -10;
   int          done_cyc = -10;
   int          next_ar_cyc = -10;
   int          done_count = 0;
   int          ar_hs_count = 0;
   int          arvalid_cycles = 0;
   bit          degenerate = 0;
   bit          ar_hs_n = 0;
   bit          r_hs_n = 0;
   logic [15:0] ar_addr_n = '0;
   logic [7:0]  ar_len_n = '0;
   int          tmode = 0;
   int          frame_cyc = 0;
   int          r_count = 0;
   int          inject_beat = -1;

   // Sample everything on the falling edge; handshakes seen here complete on the next rising edge.
   always @(negedge aclk) begin
      cyc++;
      ar_hs_n = aresetn && arvalid && arready;
      r_hs_n  = aresetn && rvalid && rready;
      ar_addr_n = araddr;
      ar_len_n  = arlen;
      if (aresetn) begin
         if (arvalid) arvalid_cycles++;
         if (start && !busy) start_cyc = cyc;
         if (cyc == start_cyc + 1) begin
            check("busy_after_start", 64'(busy), 64'(1));
            check("arvalid_after_start", 64'(arvalid), 64'(!degenerate));
         end
         if (cyc == next_ar_cyc) check("ar_after_bubble", 64'(arvalid), 64'(1));
         if (ar_hs_n) begin
            ar_t e;
            ar_hs_count++;
            if (exp_ar.size() == 0) begin
               check("unexpected_ar", 64'(araddr), 64'hFFFF_FFFF);
            end else begin
               e = exp_ar.pop_front();
               check("araddr", 64'(araddr), 64'(e.addr));
               check("arlen", 64'(arlen), 64'(e.len));
               check("ar_fixed", 64'({arid, arsize, arburst, arlock, arcache, arprot}),
                     64'({8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000}));
            end
         end
         if (tvalid && tready) begin
            beat_t b;
            check("rready_with_beat", 64'(rready), 64'(1));
            if (exp_beat.size() == 0) begin
               check("unexpected_beat", 64'(tdata), 64'h1_0000_0000);
            end else begin
               b = exp_beat.pop_front();
               check("tdata", 64'(tdata), 64'(b.data));
               check("tlast", 64'(tlast), 64'(b.last));
               check("tuser", 64'(tuser), 64'(b.user));
            end
            last_beat_cyc = cyc;
            if (rlast && exp_ar.size() > 0) next_ar_cyc = cyc + 1;
         end
         if (done) begin
            done_count++;
            done_cyc = cyc;
            check("done_latency", 64'(cyc), degenerate ? 64'(start_cyc + 1) : 64'(last_beat_cyc + 1));
            check("busy_with_done", 64'(busy), 64'(1));
         end
         if (cyc == done_cyc + 1) begin
            check("done_one_cycle", 64'(done), 64'(0));
            check("busy_drops", 64'(busy), 64'(0));
         end
      end
   end

   // AXI read slave and stream sink, driven just after the rising edge.
   initial begin
      int          rs_left;
      logic [15:0] rs_addr;
      bit          rs_active;
      rs_left = 0;
      rs_addr = '0;
      rs_active = 0;
      forever begin
         @(posedge aclk);
         #1;
         frame_cyc++;
         if (!aresetn) begin
            arready = 1'b0;
            rvalid  = 1'b0;
            rlast   = 1'b0;
            rresp   = 2'b00;
            rs_active = 0;
         end else begin
            if (ar_hs_n) begin
               rs_active = 1;
               rs_addr   = ar_addr_n;
               rs_left   = int'(ar_len_n) + 1;
            end
            if (r_hs_n) begin
               rs_addr = rs_addr + 16'd4;
               rs_left--;
               r_count++;
               rvalid = 1'b0;
               if (rs_left == 0) rs_active = 0;
            end
            if (rs_active && !rvalid && $urandom_range(0, 3) != 0) begin
               rvalid = 1'b1;
               rdata  = mem_word(rs_addr);
               rlast  = (rs_left == 1);
               rresp  = (r_count == inject_beat) ? 2'b10 : 2'b00;
               rid    = '0;
            end
            arready = ($urandom_range(0, 2) != 0);
            case (tmode)
               1:       tready = !(frame_cyc < 50 || (frame_cyc >= 52 && frame_cyc < 54));
               2:       tready = ($urandom_range(0, 1) != 0);
               default: tready = 1'b1;
            endcase
         end
      end
   end

   task automatic build_model(input logic [15:0] base, input int beats, input int lines,
                              input logic [15:0] pitch);
      for (int ln = 0; ln < lines; ln++) begin
         logic [15:0] a;
         int left;
         a    = base + 16'(ln) * pitch;
         left = beats;
         while (left > 0) begin
            int len;
            int to_page;
            ar_t  e;
            beat_t b;
            to_page = (4096 - int'(a[11:0])) / 4;
            len = left;
            if (len > MB) len = MB;
            if (len > to_page) len = to_page;
            e.addr = a;
            e.len  = 8'(len - 1);
            exp_ar.push_back(e);
            for (int i = 0; i < len; i++) begin
               b.data = mem_word(a + 16'(4 * i));
               b.last = (left == len) && (i == len - 1);
               b.user = (ln == 0) && (left == beats) && (i == 0);
               exp_beat.push_back(b);
            end
            a    = a + 16'(4 * len);
            left = left - len;
         end
      end
   endtask

   task automatic pulse_start(input logic [15:0] base, input int beats, input int lines,
                              input logic [15:0] pitch);
      @(posedge aclk);
      #2;
      base_addr  = base;
      line_beats = 16'(beats);
      line_count = 16'(lines);
      stride     = pitch;
      start      = 1'b1;
      @(posedge aclk);
      #2;
      start      = 1'b0;
      // Scramble the config inputs: the frame must run on the latched copy.
      base_addr  = 16'hDEAD;
      line_beats = 16'd3;
      line_count = 16'd5;
      stride     = 16'h0777;
   endtask

   task automatic run_frame(input logic [15:0] base, input int beats, input int lines,
                            input logic [15:0] pitch, input int mode, input bit exp_err,
                            input bit poke_busy);
      int dc0;
      int t;
      build_model(base, beats, lines, pitch);
      degenerate = (beats == 0 || lines == 0);
      tmode      = mode;
      frame_cyc  = 0;
      r_count    = 0;
      dc0        = done_count;
      pulse_start(base, beats, lines, pitch);
      if (poke_busy) begin
         repeat (6) @(posedge aclk);
         #2;
         base_addr  = 16'h0100;
         line_beats = 16'd2;
         line_count = 16'd1;
         start      = 1'b1;
         @(posedge aclk);
         #2;
         start      = 1'b0;
      end
      t = 0;
      while (done_count == dc0 && t < 20000) begin
         @(posedge aclk);
         t++;
      end
      check("done_seen", 64'(done_count > dc0), 64'(1));
      repeat (3) @(posedge aclk);
      #2;
      check("ar_queue_empty", 64'(exp_ar.size()), 64'(0));
      check("beat_queue_empty", 64'(exp_beat.size()), 64'(0));
      check("err_flag", 64'(err), 64'(exp_err));
      exp_ar.delete();
      exp_beat.delete();
      inject_beat = -1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'(0));
      check({tag, "_done"}, 64'(done), 64'(0));
      check({tag, "_err"}, 64'(err), 64'(0));
      check({tag, "_arvalid"}, 64'(arvalid), 64'(0));
      check({tag, "_rready"}, 64'(rready), 64'(0));
      check({tag, "_tvalid"}, 64'(tvalid), 64'(0));
      check({tag, "_tlast"}, 64'(tlast), 64'(0));
      check({tag, "_tuser"}, 64'(tuser), 64'(0));
      check({tag, "_araddr"}, 64'(araddr), 64'(0));
      check({tag, "_arlen"}, 64'(arlen), 64'(0));
   endtask

   initial begin
      int ar0;
      int t;
      repeat (3) @(posedge aclk);
      #2;
      check_reset_values("por");
      aresetn = 1'b1;
      repeat (2) @(posedge aclk);

      // Basic 4x8 frame, continuous tready
      run_frame(16'h0000, 8, 4, 16'd32, 0, 1'b0, 1'b0);
      // Long lines split 16/16/8, random backpressure
      run_frame(16'h0200, 40, 2, 16'h0100, 2, 1'b0, 1'b0);
      // 4 KB page split: 0x0FF0 len 4 then 0x1000 len 4
      run_frame(16'h0FF0, 8, 1, 16'd0, 0, 1'b0, 1'b0);
      // Reference tready stall pattern
      run_frame(16'h0400, 24, 3, 16'd128, 1, 1'b0, 1'b0);
      // Address wrap at top of space
      run_frame(16'hFFC0, 32, 2, 16'h0040, 2, 1'b0, 1'b0);
      // Error response is flagged but data still flows; next start clears err
      inject_beat = 5;
      run_frame(16'h0000, 8, 2, 16'd32, 0, 1'b1, 1'b0);
      run_frame(16'h0040, 4, 1, 16'd0, 0, 1'b0, 1'b0);
      // Degenerate frames issue no AR
      ar0 = arvalid_cycles;
      run_frame(16'h0100, 8, 0, 16'd32, 0, 1'b0, 1'b0);
      run_frame(16'h0100, 0, 3, 16'd32, 0, 1'b0, 1'b0);
      check("degenerate_no_ar", 64'(arvalid_cycles - ar0), 64'(0));
      // Start while busy is ignored
      run_frame(16'h0800, 40, 3, 16'h0100, 2, 1'b0, 1'b1);

      // Reset during the second burst of a frame that has already flagged an error
      build_model(16'h0100, 40, 2, 16'h0100);
      degenerate  = 0;
      tmode       = 0;
      frame_cyc   = 0;
      r_count     = 0;
      inject_beat = 1;
      ar0         = ar_hs_count;
      pulse_start(16'h0100, 40, 2, 16'h0100);
      t = 0;
      while (ar_hs_count < ar0 + 2 && t < 2000) begin
         @(posedge aclk);
         t++;
      end
      check("second_burst_reached", 64'(ar_hs_count >= ar0 + 2), 64'(1));
      repeat (2) @(posedge aclk);
      #2;
      aresetn = 1'b0;
      @(negedge aclk);
      #1;
      check_reset_values("midrst");
      repeat (3) @(posedge aclk);
      #2;
      check_reset_values("midrst_hold");
      exp_ar.delete();
      exp_beat.delete();
      next_ar_cyc = -10;
      inject_beat = -1;
      aresetn = 1'b1;
      repeat (2) @(posedge aclk);
      run_frame(16'h0300, 20, 1, 16'd0, 2, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
